// File: rtl/uart_rx_if.sv
// Byte stream from the UART receiver to its consumer: data/valid are
// offered by the receiver and taken when the consumer raises ready.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver: synchronises the serial line, samples each
// bit at its centre and hands completed bytes over a valid/ready stream.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      rx_sig_i,
  output logic      frame_err_o,
  output logic      overrun_err_o,
  uart_rx_if.master rx_if
);
  localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
  localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
  localparam int CNT_W            = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
  localparam int IDX_W            = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] PULSE_RELOAD = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD  = CNT_W'(HALF_PULSE_WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e                state_q;
  logic                  sync1_q;
  logic                  rx_s_q;
  logic                  rx_prev_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  frame_err_q;
  logic                  overrun_err_q;

  logic fall_edge;
  logic cnt_done;
  logic accept;

  // A start is only recognised on a real 1->0 transition, so a line left low
  // after a break cannot retrigger the receiver.
  assign fall_edge = rx_prev_q & ~rx_s_q;
  assign cnt_done  = (cnt_q == '0);
  assign accept    = valid_q & rx_if.ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      sync1_q       <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_prev_q     <= 1'b1;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      sync1_q       <= rx_sig_i;
      rx_s_q        <= sync1_q;
      rx_prev_q     <= rx_s_q;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;

      if (accept) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (fall_edge) begin
            state_q <= START;
            cnt_q   <= HALF_RELOAD;
          end
        end

        START: begin
          if (cnt_done) begin
            if (!rx_s_q) begin
              state_q <= DATA;
              cnt_q   <= PULSE_RELOAD;
              idx_q   <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt_done) begin
            shift_q[idx_q] <= rx_s_q;
            cnt_q          <= PULSE_RELOAD;
            if (idx_q == LAST_IDX) begin
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt_done) begin
            state_q <= IDLE;
            // A byte landing while the previous one is still unaccepted is
            // dropped so the consumer always sees stable data.
            if (rx_s_q) begin
              if (!valid_q || rx_if.ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_err_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rx_if.data    = data_q;
  assign rx_if.valid   = valid_q;
  assign frame_err_o   = frame_err_q;
  assign overrun_err_o = overrun_err_q;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: three receivers at different bit periods,
// expected bytes queued at send time and matched on each stream handshake.
module tb_uart_rx;
  localparam int P0 = 868;
  localparam int P1 = 8_000_000 / 500_000;
  localparam int P2 = 192_000 / 9600;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic rxLine [3];
  logic ferrW [3];
  logic oerrW [3];
  logic [7:0] obsData [3];
  logic obsValid [3];
  logic obsReady [3];

  uart_rx_if #(.DATA_WIDTH(8)) bus0 ();
  uart_rx_if #(.DATA_WIDTH(8)) bus1 ();
  uart_rx_if #(.DATA_WIDTH(8)) bus2 ();

  uart_rx dut0 (
    .clk(clk), .rstn(rstn), .rx_sig_i(rxLine[0]),
    .frame_err_o(ferrW[0]), .overrun_err_o(oerrW[0]), .rx_if(bus0.master)
  );

  uart_rx #(.BAUD_RATE(500_000), .CLK_FREQ(8_000_000)) dut1 (
    .clk(clk), .rstn(rstn), .rx_sig_i(rxLine[1]),
    .frame_err_o(ferrW[1]), .overrun_err_o(oerrW[1]), .rx_if(bus1.master)
  );

  uart_rx #(.BAUD_RATE(9600), .CLK_FREQ(192_000)) dut2 (
    .clk(clk), .rstn(rstn), .rx_sig_i(rxLine[2]),
    .frame_err_o(ferrW[2]), .overrun_err_o(oerrW[2]), .rx_if(bus2.master)
  );

  assign obsData[0]  = bus0.data;
  assign obsData[1]  = bus1.data;
  assign obsData[2]  = bus2.data;
  assign obsValid[0] = bus0.valid;
  assign obsValid[1] = bus1.valid;
  assign obsValid[2] = bus2.valid;
  assign obsReady[0] = bus0.ready;
  assign obsReady[1] = bus1.ready;
  assign obsReady[2] = bus2.ready;

  int checksTotal = 0;
  int checksPassed = 0;
  int deliveredCnt = 0;
  int cycleCnt = 0;
  int startCycle = 0;
  int lastDeliverCycle = 0;
  int ferrCnt [3] = '{0, 0, 0};
  int oerrCnt [3] = '{0, 0, 0};
  logic ferrPrev [3];
  logic oerrPrev [3];
  logic [15:0] expQ [$];

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checksTotal++;
    if (got === exp) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic driveBit(input int k, input logic v, input int n);
    rxLine[k] = v;
    waitCycles(n);
  endtask

  task automatic applyStimulus(input int k, input logic [7:0] b, input logic stopBit, input int pulse);
    startCycle = cycleCnt;
    driveBit(k, 1'b0, pulse);
    for (int i = 0; i < 8; i++) driveBit(k, b[i], pulse);
    driveBit(k, stopBit, pulse);
  endtask

  task automatic waitDelivered(input int n, input int budget);
    for (int i = 0; i < budget && deliveredCnt < n; i++) @(posedge clk);
    #1;
    checkOutput("delivered", deliveredCnt, n);
  endtask

  // Every handshake pops the oldest expected {instance, byte} entry.
  always @(negedge clk) begin
    if (rstn) begin
      for (int k = 0; k < 3; k++) begin
        if (obsValid[k] && obsReady[k]) begin
          deliveredCnt++;
          lastDeliverCycle = cycleCnt;
          if (expQ.size() == 0) checkOutput("sbEmpty", {8'(k), obsData[k]}, 32'hFFFF_FFFF);
          else checkOutput("rxData", {8'(k), obsData[k]}, expQ.pop_front());
        end
        if (ferrW[k]) ferrCnt[k]++;
        if (oerrW[k]) oerrCnt[k]++;
        if (ferrW[k] && ferrPrev[k]) checkOutput("ferrWidth", {ferrPrev[k], ferrW[k]}, 2'b01);
        if (oerrW[k] && oerrPrev[k]) checkOutput("oerrWidth", {oerrPrev[k], oerrW[k]}, 2'b01);
      end
    end
    for (int k = 0; k < 3; k++) begin
      ferrPrev[k] = ferrW[k];
      oerrPrev[k] = oerrW[k];
    end
  end

  initial begin
    logic [7:0] pat;
    logic [7:0] burst [3];
    int lat;
    burst = '{8'h00, 8'hFF, 8'h55};
    for (int k = 0; k < 3; k++) rxLine[k] = 1'b1;
    bus0.ready = 1'b1;
    bus1.ready = 1'b1;
    bus2.ready = 1'b1;

    waitCycles(4);
    @(negedge clk);
    checkOutput("rstValid0", obsValid[0], 0);
    checkOutput("rstValid1", obsValid[1], 0);
    checkOutput("rstData1", obsData[1], 0);
    checkOutput("rstFerr1", ferrW[1], 0);
    checkOutput("rstOerr1", oerrW[1], 0);
    checkOutput("rstValid2", obsValid[2], 0);
    waitCycles(1);
    rstn = 1'b1;
    waitCycles(4);

    $display("[TB] frame 0xA5 at default rate");
    expQ.push_back({8'd0, 8'hA5});
    applyStimulus(0, 8'hA5, 1'b1, P0);
    waitDelivered(1, 2 * P0);
    lat = lastDeliverCycle - startCycle;
    checkOutput("latencyA5", (lat >= 8245 && lat <= 8253) ? 8249 : lat, 8249);
    waitCycles(2);
    @(negedge clk);
    checkOutput("validOneCycle", obsValid[0], 0);
    checkOutput("noFerrA5", ferrCnt[0], 0);
    checkOutput("noOerrA5", oerrCnt[0], 0);

    $display("[TB] 100-cycle low glitch");
    rxLine[0] = 1'b0;
    waitCycles(100);
    rxLine[0] = 1'b1;
    waitCycles(2 * P0);
    checkOutput("glitchNoData", deliveredCnt, 1);
    checkOutput("glitchNoFerr", ferrCnt[0], 0);
    expQ.push_back({8'd0, 8'h96});
    applyStimulus(0, 8'h96, 1'b1, P0);
    waitDelivered(2, 2 * P0);

    $display("[TB] frame error then break");
    applyStimulus(1, 8'h3C, 1'b0, P1);
    checkOutput("ferrPulse", ferrCnt[1], 1);
    waitCycles(20 * P1);
    checkOutput("breakNoFerr", ferrCnt[1], 1);
    checkOutput("ferrNoData", deliveredCnt, 2);
    checkOutput("ferrValid", obsValid[1], 0);
    rxLine[1] = 1'b1;
    waitCycles(4 * P1);
    checkOutput("breakEndQuiet", ferrCnt[1] * 16 + deliveredCnt, 16 + 2);
    expQ.push_back({8'd1, 8'h81});
    applyStimulus(1, 8'h81, 1'b1, P1);
    waitDelivered(3, 4 * P1);

    $display("[TB] overrun with ready low");
    bus1.ready = 1'b0;
    expQ.push_back({8'd1, 8'h11});
    applyStimulus(1, 8'h11, 1'b1, P1);
    applyStimulus(1, 8'h22, 1'b1, P1);
    waitCycles(2 * P1);
    @(negedge clk);
    checkOutput("ovrValid", obsValid[1], 1);
    checkOutput("ovrData", obsData[1], 8'h11);
    checkOutput("ovrErr", oerrCnt[1], 1);
    checkOutput("ovrHeld", deliveredCnt, 3);
    bus1.ready = 1'b1;
    waitDelivered(4, 10);
    waitCycles(1);
    @(negedge clk);
    checkOutput("ovrCleared", obsValid[1], 0);

    $display("[TB] reset during bit 4");
    pat = 8'h5A;
    waitCycles(1);
    driveBit(1, 1'b0, P1);
    for (int i = 0; i < 4; i++) driveBit(1, pat[i], P1);
    rxLine[1] = pat[4];
    waitCycles(P1 / 2);
    rstn = 1'b0;
    waitCycles(2);
    rstn = 1'b1;
    waitCycles(P1 / 2 + 12 * P1);
    checkOutput("rstNoData", deliveredCnt, 4);
    checkOutput("rstNoFerr", ferrCnt[1], 1);
    checkOutput("rstNoOerr", oerrCnt[1], 1);
    expQ.push_back({8'd1, 8'hC3});
    applyStimulus(1, 8'hC3, 1'b1, P1);
    waitDelivered(5, 4 * P1);

    $display("[TB] back-to-back bursts");
    for (int i = 0; i < 3; i++) begin
      expQ.push_back({8'd1, burst[i]});
      applyStimulus(1, burst[i], 1'b1, P1);
    end
    waitDelivered(8, 4 * P1);
    for (int i = 0; i < 3; i++) begin
      expQ.push_back({8'd2, burst[i]});
      applyStimulus(2, burst[i], 1'b1, P2);
    end
    waitDelivered(11, 4 * P2);
    checkOutput("burstNoFerr", ferrCnt[1] + ferrCnt[2], 1);
    checkOutput("burstNoOerr", oerrCnt[1] + oerrCnt[2], 1);
    checkOutput("sbDrained", expQ.size(), 0);

    $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, data bits per frame.
REQ-002 SHALL provide parameter BAUD_RATE, default 115200, line bit rate.
REQ-003 SHALL provide parameter CLK_FREQ, default 100_000_000, clk frequency in Hz.
REQ-004 SHALL derive PULSE_WIDTH = CLK_FREQ/BAUD_RATE (integer division) and HALF_PULSE_WIDTH = PULSE_WIDTH/2; defaults 868 and 434.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rstn  input  1  reset, synchronous, active-low.
REQ-007 rx_sig  input  1  asynchronous serial line, idle high.
REQ-008 data  output  DATA_WIDTH  received byte, valid while valid=1.
REQ-009 valid  output  1  received byte available.
REQ-010 ready  input  1  consumer accepts data when valid && ready.
REQ-011 frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-012 overrun_err  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-013 SHALL pass rx_sig through a 2-flop synchronizer; all sampling uses the synchronizer output rx_s.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP; any illegal encoding SHALL go to IDLE.
REQ-015 IDLE: on rx_s high-to-low edge (previous 1, current 0), SHALL enter START and load the bit counter with HALF_PULSE_WIDTH-1; cycle of edge detection is cycle 0.
REQ-016 START: counter decrements each cycle; at 0 (cycle HALF_PULSE_WIDTH-1 after edge), SHALL sample rx_s; 0 -> DATA with counter PULSE_WIDTH-1 and bit index 0; 1 -> IDLE (glitch rejected, no output).
REQ-017 DATA: at each counter expiry SHALL sample rx_s into bit[index], LSB first, reload PULSE_WIDTH-1; after bit DATA_WIDTH-1 SHALL enter STOP.
REQ-018 STOP: at counter expiry SHALL sample rx_s; 1 -> deliver byte per REQ-019..021; 0 -> pulse frame_err one cycle, discard byte; both -> IDLE.
REQ-019 Delivery SHALL load data and set valid in the cycle after the stop sample.
REQ-020 valid SHALL stay 1 and data stable until a cycle with valid && ready; valid then clears next cycle unless REQ-021 applies.
REQ-021 Delivery in the same cycle as valid && ready: SHALL load new byte, valid stays 1, no overrun_err.
REQ-022 Delivery while valid=1 and ready=0: SHALL keep old data, drop new byte, pulse overrun_err one cycle.
REQ-023 After a frame error with line held low (break), SHALL not restart until a fresh high-to-low edge is seen.
REQ-024 Receiver SHALL keep receiving independent of ready; back-to-back frames (stop bit immediately followed by start bit) SHALL be received without loss when ready=1.
REQ-025 Bit counter width SHALL hold PULSE_WIDTH-1 without overflow; index width SHALL be $clog2(DATA_WIDTH) min 1.

Reset
REQ-026 rstn=0 SHALL force state IDLE, synchronizer flops and edge-history flop to 1, data=0, valid=0, frame_err=0, overrun_err=0, counters=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no valid, frame_err or overrun_err output; reception resumes at the next high-to-low edge after release.

Verification
REQ-028 Frame 0xA5 at defaults, 8N1, ready=1 -> valid=1 for one cycle with data=0xA5, about 9.5*868+3 cycles after the start edge on rx_sig; no error pulses.
REQ-029 rx_sig low for 100 cycles then high -> no valid, no frame_err, FSM back in IDLE.
REQ-030 Frame 0x3C with stop bit driven 0 -> frame_err one-cycle pulse, valid stays 0; line held low 20 bit times -> no further activity until next edge.
REQ-031 ready=0, frames 0x11 then 0x22 -> valid=1 data=0x11, overrun_err pulse at second delivery; after ready=1, handshake takes 0x11 and valid clears.
REQ-032 rstn pulsed low during bit 4 of 0x5A, then frame 0xC3 -> only 0xC3 delivered.
REQ-033 Frames 0x00, 0xFF, 0x55 back-to-back with ready=1; repeat with BAUD_RATE=9600 -> all three delivered in order.
